dyn_pattern: RTL and testbench
==============================

# dyn_pattern

Serial bit-pattern detector that watches a 1-bit data stream and flags each occurrence of a compile-time pattern of parameterizable length. It is a Moore-style explicit state machine: the state is the number of pattern bits currently matched, and mismatches fall back to the longest still-valid partial match. It sits directly on a serial receive path and feeds a one-cycle match pulse to downstream control logic.

## Interface
- pattern, default 5'b10110 — bit sequence to detect, MSB is the first bit expected on the wire; only bits [num_bits-1:0] are used.
- num_bits, default 5 — pattern length; legal range 1..16.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-high reset (port keeps the codebase name rstn; asserted = 1).
- data  input  1  serial data bit, sampled on rising clk edge.
- valid  input  1  qualifies data; bit is consumed only when valid=1.
- state  output  5  current matched-prefix length, binary, range 0..num_bits-1.
- detect  output  1  registered match pulse.

## Operation
- States S0..S(num_bits-1); Sk = first k pattern bits matched (pattern[num_bits-1] down to pattern[num_bits-k]).
- On an edge with valid=1 and state=k:
  - if data equals the next expected bit pattern[num_bits-1-k] and k+1 < num_bits: state ← k+1, detect ← 0.
  - if data completes the pattern (k+1 = num_bits): detect ← 1; state ← fallback length of the full pattern (see Configuration).
  - otherwise: state ← longest j < k+1 such that the first j pattern bits equal the last j bits of (matched prefix followed by data); detect ← 0.
- Fallback/transition table computed at elaboration from pattern and num_bits (constant function or generate); no runtime pattern loading.
- valid=0: state held, detect ← 0.
- Upper state bits beyond what num_bits requires are driven 0.

## Timing
- Reset (rstn=1, async): state=0, detect=0 immediately; held while asserted. First bit consumed on first rising edge after deassertion with valid=1.
- Latency: detect rises on the same edge that samples the final pattern bit; high for exactly one cycle unless the next bit completes another match.
- state updates every valid edge; no idle/bubble cycles required between matches.
- Reset mid-pattern discards partial match; no detection carried over.
- data/valid must be stable around the rising edge; no other handshake.

## Configuration
- DYN_PATT_OVERLAP_EN defined: overlapping detection — after a full match state ← length of longest proper suffix of pattern that is also a prefix (pattern 10110 → S2).
- Not defined: non-overlapping — after a full match state ← 0 and the bits of the completed match are not reused.

## Test plan
- Reset: hold rstn=1 with toggling data/valid → state=0, detect=0 throughout; release and feed 1,0,1,1,0 (valid=1) → state 1,2,3,4, then detect=1 on 5th edge.
- Overlap (macro defined): feed 1,0,1,1,0,1,1,0 → detect pulses after bits 5 and 8; state after bit 5 = 2.
- Non-overlap (macro undefined): same stream → single detect after bit 5; state after bit 5 = 0, after bits 6,7,8 = 1,1,2.
- Mismatch fallback: feed 1,0,1,0,1,1,0 → state 1,2,3,2,3,4, detect=1 on bit 7.
- valid gating: feed 1,0,1 with valid=1, then 3 cycles valid=0 with data=0 → state stays 3, detect=0; resume 1,0 → detect=1.
- Random: 300 random bits vs. software reference model → detect and state match every cycle.

Source files
------------

// File: rtl/dyn_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : dyn_pattern
//  Description : Serial bit-pattern detector. Moore FSM whose state is the
//                number of pattern bits currently matched; mismatches fall
//                back to the longest prefix that is still a suffix of the
//                observed stream. Emits a registered one-cycle match pulse.
//                Optional macro DYN_PATT_OVERLAP_EN enables overlapping
//                detection (bits of a completed match may start the next).
//  Revision    : 1.0 - initial release
// ============================================================================
module dyn_pattern #(
  parameter logic [15:0] pattern  = 16'b0000_0000_0001_0110,
  parameter int          num_bits = 5
) (
  input  logic       clk,
  input  logic       rstn,    // asynchronous, active-high (asserted = 1)
  input  logic       data,
  input  logic       valid,
  output logic [4:0] state,
  output logic       detect
);

  typedef enum logic [4:0] {
    S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,
    S8,  S9,  S10, S11, S12, S13, S14, S15
  } state_e;

  // i-th bit on the wire (i = 0 is the first bit expected)
  function automatic logic f_pbit(input int i);
    logic [15:0] t;
    t = pattern >> (num_bits - 1 - i);
    return t[0];
  endfunction

  // Longest j (capped at num_bits-1) such that the first j pattern bits equal
  // the last j bits of (first k pattern bits followed by b). With the cap, a
  // completed pattern yields its longest proper suffix that is also a prefix.
  function automatic logic [4:0] f_next(input int k, input logic b);
    logic [4:0] best;
    logic       ok;
    logic       sb;
    int         si;
    best = '0;
    for (int j = 1; j <= 16; j++) begin
      if ((j <= k + 1) && (j <= num_bits - 1)) begin
        ok = 1'b1;
        for (int m = 0; m < 16; m++) begin
          if (m < j) begin
            si = k + 1 - j + m;
            sb = (si == k) ? b : f_pbit(si);
            if (sb != f_pbit(m)) ok = 1'b0;
          end
        end
        if (ok) best = 5'(j);
      end
    end
    return best;
  endfunction

  localparam logic [4:0] c_LAST_STATE = 5'(num_bits - 1);
  localparam logic       c_LAST_BIT   = f_pbit(num_bits - 1);
`ifdef DYN_PATT_OVERLAP_EN
  localparam logic [4:0] c_FULL_FB    = f_next(num_bits - 1, c_LAST_BIT);
`else
  localparam logic [4:0] c_FULL_FB    = 5'd0;
`endif

  // Elaboration-time transition table, indexed [state][data]
  logic [31:0][1:0][4:0] w_next;

  for (genvar k = 0; k < 32; k++) begin : g_row
    if (k < num_bits) begin : g_used
      assign w_next[k][0] = f_next(k, 1'b0);
      assign w_next[k][1] = f_next(k, 1'b1);
    end else begin : g_unused
      assign w_next[k][0] = 5'd0;
      assign w_next[k][1] = 5'd0;
    end
  end

  state_e     state_q, state_d;
  logic       detect_q, detect_d;
  logic [4:0] w_idx;

  assign w_idx = state_q;

  // Next-state and match-pulse decode; idle cycles hold state and clear detect
  always_comb begin
    state_d  = state_q;
    detect_d = 1'b0;
    if (valid) begin
      if ((w_idx == c_LAST_STATE) && (data == c_LAST_BIT)) begin
        detect_d = 1'b1;
        state_d  = state_e'(c_FULL_FB);
      end else begin
        state_d  = state_e'(w_next[w_idx][data]);
      end
    end
  end

  // State and detect registers; reset discards any partial match at once
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= S0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
    end
  end

  assign state  = state_q;
  assign detect = detect_q;

endmodule
`default_nettype wire

// File: tb/tb_dyn_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dyn_pattern
//  Description : Scoreboard bench for dyn_pattern (pattern 10110, 5 bits).
//                Driver pushes expected (state, detect) per clock; a monitor
//                pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dyn_pattern;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic       data  = 1'b0;
  logic       valid = 1'b0;
  logic [4:0] state;
  logic       detect;

`ifdef DYN_PATT_OVERLAP_EN
  localparam logic [4:0] FB = 5'd2;
`else
  localparam logic [4:0] FB = 5'd0;
`endif

  typedef struct {
    logic [4:0] st;
    logic       det;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dyn_pattern dut (
    .clk    (clk),
    .rstn   (rstn),
    .data   (data),
    .valid  (valid),
    .state  (state),
    .detect (detect)
  );

  task automatic check(input string tag, input logic [4:0] es, input logic ed);
    n_checks++;
    if (state === es && detect === ed) n_pass++;
    else $display("FAIL %s: got state=%0d detect=%0b, expected state=%0d detect=%0b",
                  tag, state, detect, es, ed);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, e.st, e.det);
    end
  end

  task automatic step(input logic v, input logic d, input logic [4:0] es,
                      input logic ed, input string tag);
    exp_t e;
    @(negedge clk);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    e.st = es; e.det = ed; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    #1 rstn = 1'b1;
    #2 check({tag, "_async"}, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'($urandom);
      data  = 1'($urandom);
      @(posedge clk);
      #1;
      e.st = 5'd0; e.det = 1'b0; e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    rstn  = 1'b0;
    valid = 1'b0;
    data  = 1'b0;
  endtask

  initial begin
    int guard;
    do_reset("rst0");

    // Basic detection of 10110
    step(1, 1, 5'd1, 0, "basic_b1");
    step(1, 0, 5'd2, 0, "basic_b2");
    step(1, 1, 5'd3, 0, "basic_b3");
    step(1, 1, 5'd4, 0, "basic_b4");
    step(1, 0, FB,   1, "basic_b5");
    // Continue with 1,1,0: overlap vs non-overlap
`ifdef DYN_PATT_OVERLAP_EN
    step(1, 1, 5'd3, 0, "ovl_b6");
    step(1, 1, 5'd4, 0, "ovl_b7");
    step(1, 0, 5'd2, 1, "ovl_b8");
`else
    step(1, 1, 5'd1, 0, "novl_b6");
    step(1, 1, 5'd1, 0, "novl_b7");
    step(1, 0, 5'd2, 0, "novl_b8");
`endif

    // Mismatch fallback: 1,0,1,0,1,1,0
    do_reset("rst1");
    step(1, 1, 5'd1, 0, "mis_b1");
    step(1, 0, 5'd2, 0, "mis_b2");
    step(1, 1, 5'd3, 0, "mis_b3");
    step(1, 0, 5'd2, 0, "mis_b4");
    step(1, 1, 5'd3, 0, "mis_b5");
    step(1, 1, 5'd4, 0, "mis_b6");
    step(1, 0, FB,   1, "mis_b7");
    step(0, 0, FB,   0, "mis_pulse_end");

    // valid gating
    do_reset("rst2");
    step(1, 1, 5'd1, 0, "gate_b1");
    step(1, 0, 5'd2, 0, "gate_b2");
    step(1, 1, 5'd3, 0, "gate_b3");
    step(0, 0, 5'd3, 0, "gate_idle1");
    step(0, 0, 5'd3, 0, "gate_idle2");
    step(0, 0, 5'd3, 0, "gate_idle3");
    step(1, 1, 5'd4, 0, "gate_b4");
    step(1, 0, FB,   1, "gate_b5");

    // Reset mid-pattern discards partial match
    do_reset("rst3");
    step(1, 1, 5'd1, 0, "mid_b1");
    step(1, 0, 5'd2, 0, "mid_b2");
    step(1, 1, 5'd3, 0, "mid_b3");
    do_reset("rst_mid");
    step(1, 1, 5'd4 - 5'd3, 0, "after_rst_b1");
    step(1, 0, 5'd2, 0, "after_rst_b2");

    // Misc fallbacks: 0,0,1,1,0,1,0,1,1,0 from S2
    step(1, 0, 5'd0, 0, "zero_from_s2");
    step(1, 0, 5'd0, 0, "zero_hold");
    step(1, 1, 5'd1, 0, "ones_b1");
    step(1, 1, 5'd1, 0, "ones_b2");
    step(1, 0, 5'd2, 0, "ones_b3");
    step(1, 1, 5'd3, 0, "ones_b4");
    step(1, 0, 5'd2, 0, "s3_miss");
    step(1, 1, 5'd3, 0, "re_b3");
    step(1, 1, 5'd4, 0, "re_b4");
    step(1, 0, FB,   1, "re_b5");
    step(1, 0, (FB == 5'd2) ? 5'd0 : 5'd0, 0, "post_det_zero");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
